// File: rtl/logarithm.sv
// Registered floor(log2) unit: leading-one index, Mitchell-style fraction and
// zero / power-of-two flags, one cycle of latency at one sample per cycle.
module logarithm #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned RW     = $clog2(WIDTH),
  parameter int unsigned FRAC_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  number,
  input  logic              in_valid,
  output logic [RW-1:0]     result,
  output logic [FRAC_W-1:0] frac,
  output logic              is_pow2,
  output logic              zero,
  output logic              out_valid
);

  // Mantissa bits below the leading one, padded so any FRAC_W fits.
  localparam int unsigned EXT_W = WIDTH - 1 + FRAC_W;

  logic [RW-1:0]     msb_c;
  logic [WIDTH-1:0]  norm_c;
  logic [EXT_W-1:0]  ext_c;
  logic [FRAC_W-1:0] frac_c;
  logic              zero_c;
  logic              pow2_c;

  // Priority encoder: the highest set bit wins; zero operand yields 0.
  always_comb begin
    msb_c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (number[i]) msb_c = RW'(i);
    end
  end

  // Normalise so the leading one lands on bit WIDTH-1, then take the bits
  // immediately below it, truncated or zero-filled to FRAC_W.
  always_comb begin
    norm_c = number << (RW'(WIDTH - 1) - msb_c);
    ext_c  = {norm_c[WIDTH-2:0], {FRAC_W{1'b0}}};
    frac_c = ext_c[EXT_W-1 -: FRAC_W];
  end

  always_comb begin
    zero_c = (number == '0);
    pow2_c = !zero_c && ((number & (number - WIDTH'(1))) == '0);
  end

  // Output stage: data holds when no sample is accepted; reset wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      result    <= '0;
      frac      <= '0;
      is_pow2   <= 1'b0;
      zero      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result  <= msb_c;
        frac    <= frac_c;
        is_pow2 <= pow2_c;
        zero    <= zero_c;
      end
    end
  end

endmodule

// File: tb/tb_logarithm.sv
// Directed and exhaustive checks for the registered log2 unit.
module tb_logarithm;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned RW     = 3;
  localparam int unsigned FRAC_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [WIDTH-1:0]  number = '0;
  logic              in_valid = 1'b0;
  logic [RW-1:0]     result;
  logic [FRAC_W-1:0] frac;
  logic              is_pow2;
  logic              zero;
  logic              out_valid;

  int n_vec = 0;
  int n_err = 0;

  logarithm #(.WIDTH(WIDTH), .RW(RW), .FRAC_W(FRAC_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .number   (number),
    .in_valid (in_valid),
    .result   (result),
    .frac     (frac),
    .is_pow2  (is_pow2),
    .zero     (zero),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive between edges, then sample just after the capturing edge.
  task automatic step(input int n, input logic v, input logic r);
    @(negedge clk);
    number   = WIDTH'(n);
    in_valid = v;
    rst      = r;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input int r, input int f,
                            input int p, input int z, input int ov);
    check({tag, ".result"},    int'(result),    r);
    check({tag, ".frac"},      int'(frac),      f);
    check({tag, ".is_pow2"},   int'(is_pow2),   p);
    check({tag, ".zero"},      int'(zero),      z);
    check({tag, ".out_valid"}, int'(out_valid), ov);
  endtask

  initial begin
    int ref_r, ref_f, rem, t;

    // Reset state
    step(0, 1'b0, 1'b1);
    step(0, 1'b0, 1'b1);
    expect_out("reset", 0, 0, 0, 0, 0);

    // Powers of two, back to back
    for (int i = 0; i < 8; i++) begin
      step(1 << i, 1'b1, 1'b0);
      expect_out($sformatf("pow2_%0d", 1 << i), i, 0, 1, 0, 1);
    end

    // Non-powers with hand-computed fractions
    step(3,   1'b1, 1'b0); expect_out("n3",   1, 4'b1000, 0, 0, 1);
    step(96,  1'b1, 1'b0); expect_out("n96",  6, 4'b1000, 0, 0, 1);
    step(255, 1'b1, 1'b0); expect_out("n255", 7, 4'b1111, 0, 0, 1);
    step(129, 1'b1, 1'b0); expect_out("n129", 7, 4'b0000, 0, 0, 1);
    step(5,   1'b1, 1'b0); expect_out("n5",   2, 4'b0100, 0, 0, 1);
    step(27,  1'b1, 1'b0); expect_out("n27",  4, 4'b1011, 0, 0, 1);

    // Zero operand
    step(0, 1'b1, 1'b0);   expect_out("zero", 0, 0, 0, 1, 1);

    // Valid gating: outputs hold, out_valid drops
    step(8,  1'b1, 1'b0);  expect_out("gate_in", 3, 0, 1, 0, 1);
    step(64, 1'b0, 1'b0);  expect_out("gate_hold", 3, 0, 1, 0, 0);
    step(64, 1'b0, 1'b0);  expect_out("gate_hold2", 3, 0, 1, 0, 0);

    // Reset mid-stream: the sample on the reset edge is dropped
    step(2, 1'b1, 1'b0);   expect_out("rs_2", 1, 0, 1, 0, 1);
    step(4, 1'b1, 1'b1);   expect_out("rs_rst", 0, 0, 0, 0, 0);
    step(8, 1'b1, 1'b0);   expect_out("rs_8", 3, 0, 1, 0, 1);

    // Exhaustive sweep against an arithmetic reference
    for (int n = 0; n < 256; n++) begin
      ref_r = 0;
      t = n;
      while (t > 1) begin
        t = t / 2;
        ref_r++;
      end
      rem   = (n == 0) ? 0 : n - (1 << ref_r);
      ref_f = (rem * (1 << FRAC_W)) / (1 << ref_r);
      step(n, 1'b1, 1'b0);
      expect_out($sformatf("ex%0d", n), ref_r, ref_f,
                 (n != 0 && rem == 0) ? 1 : 0, (n == 0) ? 1 : 0, 1);
    end

    step(0, 1'b0, 1'b0);
    check("tail.out_valid", int'(out_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
